// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM state encodings and datapath widths for the accumulator CPU.
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_NOT   = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_JZ    = 4'h9;
    localparam logic [3:0] OP_DIV   = 4'hA;
    localparam logic [3:0] OP_SHL   = 4'hB;
    localparam logic [3:0] OP_SHR   = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [3:0] {
        S_F0   = 4'd0,
        S_F1   = 4'd1,
        S_F2   = 4'd2,
        S_DEC  = 4'd3,
        S_RD   = 4'd4,
        S_EX   = 4'd5,
        S_WR   = 4'd6,
        S_DS   = 4'd7,
        S_DW   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    // Instructions that fetch a second word from RAM before executing.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_AND)  || (op == OP_OR)  || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational accumulator ALU; result wraps modulo 2^DATA_W, zero flags a zero result.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] mdr,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = acc;
        case (opcode)
            OP_LOAD: result = mdr;
            OP_ADD:  result = acc + mdr;
            OP_SUB:  result = acc - mdr;
            OP_AND:  result = acc & mdr;
            OP_OR:   result = acc | mdr;
            OP_NOT:  result = ~acc;
            OP_SHL:  result = acc << 1;
            OP_SHR:  result = acc >> 1;
            default: result = acc;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/acc_cpu_control.sv
// Fetch/decode/execute sequencer for the accumulator CPU; computes every register
// next-value combinationally from the current register file outputs.
//
// state | meaning
// F0    | MAR <- PC
// F1    | MDR <- RAM[MAR] (instruction word)
// F2    | IR <- MDR, PC <- PC + 1
// DEC   | decode; single-cycle ops and jumps complete here
// RD    | MDR <- RAM[MAR] (operand)
// EX    | ALU result into ACC, or divide dispatch
// WR    | RAM[MAR] <- ACC
// DS    | pulse divider load
// DW    | wait for divider, ACC <- quotient
// HALT  | stopped until reset
module acc_cpu_control
    import cpu_pkg::*;
#(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PC_reg,
    input  logic [DATA_W-1:0] IR_reg,
    input  logic [DATA_W-1:0] ACC_reg,
    input  logic [DATA_W-1:0] MDR_reg,
    input  logic [ADDR_W-1:0] MAR_reg,
    input  logic              Zflag_reg,
    input  logic [DATA_W-1:0] mem_q,
    input  logic [DATA_W-1:0] div_q,
    input  logic              div_done,
    output logic [ADDR_W-1:0] PC_next,
    output logic [DATA_W-1:0] IR_next,
    output logic [DATA_W-1:0] ACC_next,
    output logic [DATA_W-1:0] MDR_next,
    output logic [ADDR_W-1:0] MAR_next,
    output logic              zflag_next,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d,
    output logic              div_load,
    output logic [DATA_W-1:0] div_a,
    output logic [DATA_W-1:0] div_b,
    output logic              halted,
    output logic [3:0]        state_o
);

    state_t state, state_next;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              unused_ir_bits;

    assign opcode         = IR_reg[DATA_W-1 -: 4];
    assign operand        = IR_reg[ADDR_W-1:0];
    assign unused_ir_bits = ^IR_reg[DATA_W-5:ADDR_W];

    assign mem_addr = MAR_reg;
    assign mem_d    = ACC_reg;
    assign div_a    = ACC_reg;
    assign div_b    = MDR_reg;
    assign state_o  = state;

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode (opcode),
        .acc    (ACC_reg),
        .mdr    (MDR_reg),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_F0;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        PC_next    = PC_reg;
        IR_next    = IR_reg;
        ACC_next   = ACC_reg;
        MDR_next   = MDR_reg;
        MAR_next   = MAR_reg;
        zflag_next = Zflag_reg;
        mem_we     = 1'b0;
        div_load   = 1'b0;
        halted     = 1'b0;
        // Reset masks every strobe combinationally, so a pulse mid-cycle drops them at once.
        if (!rst) begin
            case (state)
                S_F0: begin
                    MAR_next   = PC_reg;
                    state_next = S_F1;
                end
                S_F1: begin
                    MDR_next   = mem_q;
                    state_next = S_F2;
                end
                S_F2: begin
                    IR_next    = MDR_reg;
                    PC_next    = PC_reg + 1'b1;
                    state_next = S_DEC;
                end
                S_DEC: begin
                    if (is_mem_op(opcode) || opcode == OP_STORE) MAR_next = operand;
                    case (opcode)
                        OP_JMP: PC_next = operand;
                        OP_JZ:  if (Zflag_reg) PC_next = operand;
                        OP_NOT, OP_SHL, OP_SHR: begin
                            ACC_next   = alu_result;
                            zflag_next = alu_zero;
                        end
                        default: ;
                    endcase
                    if (opcode == OP_STORE)     state_next = S_WR;
                    else if (is_mem_op(opcode)) state_next = S_RD;
                    else if (opcode == OP_HALT) state_next = S_HALT;
                    else                        state_next = S_F0;
                end
                S_WR: begin
                    mem_we     = 1'b1;
                    state_next = S_F0;
                end
                S_RD: begin
                    MDR_next   = mem_q;
                    state_next = S_EX;
                end
                S_EX: begin
                    if (opcode == OP_DIV) begin
                        if (MDR_reg == '0) begin
                            ACC_next   = '1;
                            zflag_next = 1'b0;
                            state_next = S_F0;
                        end else begin
                            state_next = S_DS;
                        end
                    end else begin
                        ACC_next   = alu_result;
                        zflag_next = alu_zero;
                        state_next = S_F0;
                    end
                end
                S_DS: begin
                    div_load   = 1'b1;
                    state_next = S_DW;
                end
                S_DW: begin
                    if (div_done) begin
                        ACC_next   = div_q;
                        zflag_next = (div_q == '0);
                        state_next = S_F0;
                    end
                end
                S_HALT: halted = 1'b1;
                default: state_next = S_F0;
            endcase
        end
    end

endmodule
